// File: rtl/decoder_scan_en_pkg.sv
// decoder_pkg: shared types for the scanning one-hot decoder.
// Exports state_e (IDLE/HOLD/SCAN) and the mode encodings.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_en_if.sv
// decoder_scan_en_if: control/code bundle of the scanning decoder.
// master drives en/mode/sel_valid/sel; slave returns ready, y, idx, pulses.
interface decoder_scan_en_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4
);
  logic               en;
  logic               mode;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               sel_ready;
  logic [0:NUM_OUT-1] y;
  logic [SEL_W-1:0]   cur_idx;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, sel_valid, sel,
    input  sel_ready, y, cur_idx, wrap, err
  );

  modport slave (
    input  en, mode, sel_valid, sel,
    output sel_ready, y, cur_idx, wrap, err
  );
endinterface

// File: rtl/decoder_scan_en_onehot_dec.sv
// onehot_dec: combinational idx -> one-hot line vector, blank = none.
// Ports: idx (code), blank (force inactive), line [0:NUM_OUT-1].
module onehot_dec #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [SEL_W-1:0]   idx,
  input  logic               blank,
  output logic [0:NUM_OUT-1] line
);

  always_comb begin
    line = '0;
    if (!blank) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        line[i] = (int'(idx) == i);
      end
    end
    if (ACTIVE_LOW) line = ~line;
  end

endmodule

// File: rtl/decoder_scan_en.sv
// decoder_scan_en: registered one-hot decoder with DIRECT and SCAN modes.
// Ports: clk, rst_n (sync, active-low), bus (decoder_scan_en_if.slave).
module decoder_scan_en
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  decoder_scan_en_if.slave  bus
);

  localparam int DW = $clog2(DWELL) + 1;
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(NUM_OUT - 1);
  localparam logic [DW-1:0] DEND = DW'(DWELL - 1);
  localparam logic [0:NUM_OUT-1] Y_OFF =
    {NUM_OUT{ACTIVE_LOW}};

  state_e             st;
  state_e             ns;
  logic [SEL_W-1:0]   ni;
  logic [DW-1:0]      dwell;
  logic [DW-1:0]      nd;
  logic               nwrap;
  logic               acc;
  logic               bad;
  logic               ok;
  logic [0:NUM_OUT-1] ny;

  assign bus.sel_ready = bus.en
                      && (bus.mode == MODE_DIRECT);
  assign acc = bus.sel_valid && bus.sel_ready;
  assign bad = acc && (int'(bus.sel) >= NUM_OUT);
  assign ok  = acc && !bad;

  always_comb begin
    ns    = st;
    ni    = bus.cur_idx;
    nd    = dwell;
    nwrap = 1'b0;
    if (!bus.en) begin
      ns = IDLE;
      nd = '0;
    end else begin
      unique case (st)
        IDLE, HOLD: begin
          if (bus.mode == MODE_SCAN) begin
            ns = SCAN;
            nd = '0;
          end else if (ok) begin
            ns = HOLD;
            ni = bus.sel;
          end
        end
        SCAN: begin
          if (bus.mode == MODE_DIRECT) begin
            ns = HOLD;
            nd = '0;
            if (ok) ni = bus.sel;
          end else if (dwell == DEND) begin
            nd    = '0;
            nwrap = (bus.cur_idx == LAST);
            ni    = nwrap ? '0
                          : bus.cur_idx + 1'b1;
          end else begin
            nd = dwell + 1'b1;
          end
        end
        default: begin
          ns = IDLE;
          nd = '0;
        end
      endcase
    end
  end

  // y is decoded from next-state values so the
  // register output switches cleanly with cur_idx.
  onehot_dec #(
    .SEL_W      (SEL_W),
    .NUM_OUT    (NUM_OUT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .idx   (ni),
    .blank (ns == IDLE),
    .line  (ny)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      bus.cur_idx <= '0;
      dwell       <= '0;
      bus.y       <= Y_OFF;
      bus.wrap    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      st          <= ns;
      bus.cur_idx <= ni;
      dwell       <= nd;
      bus.y       <= ny;
      bus.wrap    <= nwrap;
      bus.err     <= bad;
    end
  end

endmodule

// File: tb/tb_decoder_scan_en.sv
// tb_decoder_scan_en: three decoder configs driven in parallel,
// compared each cycle against a behavioural model plus literals.
module tb_decoder_scan_en;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       sv;
  logic [1:0] sel;

  int n_chk  = 0;
  int n_pass = 0;

  decoder_scan_en_if #(.SEL_W(2), .NUM_OUT(4)) ifa ();
  decoder_scan_en_if #(.SEL_W(2), .NUM_OUT(3)) ifb ();
  decoder_scan_en_if #(.SEL_W(2), .NUM_OUT(4)) ifc ();

  assign ifa.en = en;
  assign ifa.mode = mode;
  assign ifa.sel_valid = sv;
  assign ifa.sel = sel;
  assign ifb.en = en;
  assign ifb.mode = mode;
  assign ifb.sel_valid = sv;
  assign ifb.sel = sel;
  assign ifc.en = en;
  assign ifc.mode = mode;
  assign ifc.sel_valid = sv;
  assign ifc.sel = sel;

  decoder_scan_en #(
    .SEL_W(2), .NUM_OUT(4), .DWELL(3), .ACTIVE_LOW(1'b0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  decoder_scan_en #(
    .SEL_W(2), .NUM_OUT(3), .DWELL(3), .ACTIVE_LOW(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  decoder_scan_en #(
    .SEL_W(2), .NUM_OUT(4), .DWELL(3), .ACTIVE_LOW(1'b1)
  ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:3] yv [3];
  logic [1:0] iv [3];
  logic       wv [3];
  logic       ev [3];
  logic       rv [3];

  assign yv[0] = ifa.y;
  assign yv[1] = {ifb.y, 1'b0};
  assign yv[2] = ifc.y;
  assign iv[0] = ifa.cur_idx;
  assign iv[1] = ifb.cur_idx;
  assign iv[2] = ifc.cur_idx;
  assign wv[0] = ifa.wrap;
  assign wv[1] = ifb.wrap;
  assign wv[2] = ifc.wrap;
  assign ev[0] = ifa.err;
  assign ev[1] = ifb.err;
  assign ev[2] = ifc.err;
  assign rv[0] = ifa.sel_ready;
  assign rv[1] = ifb.sel_ready;
  assign rv[2] = ifc.sel_ready;

  int cfg_n  [3] = '{4, 3, 4};
  int cfg_d  [3] = '{3, 3, 3};
  int cfg_al [3] = '{0, 0, 1};

  // on: 0 = no line shown, 1 = held, 2 = scanning
  typedef struct {
    int on;
    int idx;
    int dw;
    bit wr;
    bit er;
  } ms_t;

  ms_t m [3];
  bit  started = 1'b0;

  function automatic ms_t nxt(ms_t s, int k);
    ms_t r;
    bit  take;
    bit  inval;
    r     = s;
    r.wr  = 1'b0;
    take  = sv && en && !mode;
    inval = take && (int'(sel) >= cfg_n[k]);
    r.er  = inval;
    if (!rst_n) begin
      r = '{0, 0, 0, 1'b0, 1'b0};
    end else if (!en) begin
      r.on = 0;
      r.dw = 0;
    end else if (mode) begin
      if (s.on != 2) begin
        r.on = 2;
        r.dw = 0;
      end else if (s.dw == cfg_d[k] - 1) begin
        r.dw  = 0;
        r.idx = (s.idx + 1) % cfg_n[k];
        r.wr  = (r.idx == 0);
      end else begin
        r.dw = s.dw + 1;
      end
    end else begin
      if (take && !inval) begin
        r.on  = 1;
        r.idx = int'(sel);
      end else if (s.on == 2) begin
        r.on = 1;
      end
      r.dw = 0;
    end
    return r;
  endfunction

  function automatic logic [0:3] exp_y(int k);
    logic [0:3] e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[i] = (i < cfg_n[k])
          && (((m[k].on != 0) && (m[k].idx == i))
              != (cfg_al[k] != 0));
    end
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) m[k] <= nxt(m[k], k);
    started <= 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h t=%0t",
                  nm, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("y[%0d]", k), 32'(yv[k]), 32'(exp_y(k)));
        chk($sformatf("idx[%0d]", k), 32'(iv[k]),
            32'(m[k].idx[1:0]));
        chk($sformatf("wrap[%0d]", k), 32'(wv[k]), 32'(m[k].wr));
        chk($sformatf("err[%0d]", k), 32'(ev[k]), 32'(m[k].er));
        chk($sformatf("rdy[%0d]", k), 32'(rv[k]),
            32'(en && !mode));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [0:3] one;
  int         line;

  initial begin
    one   = 4'b1000;
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    sv    = 1'b0;
    sel   = 2'd0;
    cyc(2);
    chk("rst_y_a", 32'(ifa.y), 32'h0);
    chk("rst_idx_a", 32'(ifa.cur_idx), 32'h0);
    chk("rst_wrap_a", 32'(ifa.wrap), 32'h0);
    chk("rst_err_a", 32'(ifa.err), 32'h0);
    chk("rst_rdy_a", 32'(ifa.sel_ready), 32'h1);
    chk("rst_y_c", 32'(ifc.y), 32'hF);
    rst_n = 1'b1;

    sv = 1'b1; sel = 2'd2;
    cyc(1);
    sv = 1'b0;
    chk("dir2_a", 32'(ifa.y), 32'(4'b0010));
    chk("dir2_b", 32'(yv[1]), 32'(4'b0010));
    chk("dir2_c", 32'(ifc.y), 32'(4'b1101));
    cyc(10);
    chk("hold_a", 32'(ifa.y), 32'(4'b0010));

    sv = 1'b1; sel = 2'd3;
    cyc(1);
    sv = 1'b0;
    chk("dir3_a", 32'(ifa.y), 32'(4'b0001));
    chk("bad_err_b", 32'(ifb.err), 32'h1);
    chk("bad_y_b", 32'(yv[1]), 32'(4'b0010));
    cyc(1);
    chk("bad_err_b_low", 32'(ifb.err), 32'h0);

    sv = 1'b1; sel = 2'd0;
    cyc(1);
    sv = 1'b0;
    chk("dir0_a", 32'(ifa.y), 32'(4'b1000));

    en = 1'b0;
    cyc(1);
    chk("idle_a", 32'(ifa.y), 32'h0);
    chk("idle_c", 32'(ifc.y), 32'hF);
    chk("idle_rdy", 32'(ifa.sel_ready), 32'h0);

    en = 1'b1; mode = 1'b1;
    cyc(1);
    chk("scan0_a", 32'(ifa.y), 32'(4'b1000));
    chk("scan_rdy", 32'(ifa.sel_ready), 32'h0);
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      line = (c / 3) % 4;
      chk($sformatf("scan_a_%0d", c), 32'(ifa.y),
          32'(one >> line));
      chk($sformatf("scanw_a_%0d", c), 32'(ifa.wrap),
          32'(c == 12));
      if (c == 9) chk("scanw_b", 32'(ifb.wrap), 32'h1);
    end

    cyc(7);
    chk("mid_a", 32'(ifa.y), 32'(4'b0010));
    en = 1'b0;
    cyc(1);
    chk("drop_a", 32'(ifa.y), 32'h0);
    chk("drop_idx_a", 32'(ifa.cur_idx), 32'h2);
    en = 1'b1;
    cyc(1);
    chk("resume1_a", 32'(ifa.y), 32'(4'b0010));
    cyc(2);
    chk("resume3_a", 32'(ifa.y), 32'(4'b0010));
    cyc(1);
    chk("resume4_a", 32'(ifa.y), 32'(4'b0001));

    rst_n = 1'b0;
    cyc(1);
    chk("mrst_y_a", 32'(ifa.y), 32'h0);
    chk("mrst_idx_a", 32'(ifa.cur_idx), 32'h0);
    chk("mrst_y_c", 32'(ifc.y), 32'hF);
    rst_n = 1'b1;

    cyc(4);
    chk("rescan_a", 32'(ifa.y), 32'(4'b0100));
    mode = 1'b0;
    cyc(1);
    chk("freeze1_a", 32'(ifa.y), 32'(4'b0100));
    cyc(3);
    chk("freeze4_a", 32'(ifa.y), 32'(4'b0100));

    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) == 0) ? ~mode : mode;
      sv   = $urandom_range(0, 1) == 1;
      sel  = 2'($urandom_range(0, 3));
      cyc(1);
    end

    sv = 1'b0;
    cyc(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
